ext_code_seq: RTL and testbench

- Parametrised successor of the 32-channel, 8-page external code sequencer.
- Holds DEPTH pages of CH_W-bit output codes, all written over the control bus.
- An external timing trigger steps through a programmed page range: up or down, one-shot or looping, modulo DEPTH.
- Fully synchronous to iClk: the asynchronous trigger is synchronised internally, and page/status readback is provided for the host.

---
 rtl/ext_code_pkg.sv | 23 ++
 rtl/trig_sync_edge.sv | 21 ++
 rtl/ext_code_seq.sv | 119 +++++++++++
 tb/tb_ext_code_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_code_pkg.sv
// Shared types and helpers for the external code sequencer: state encoding,
// step direction constants and the modulo-DEPTH page stepping rule.
package ext_code_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    OUTPUT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Pages form a ring, so stepping past either end wraps to the other side.
  function automatic logic [31:0] next_index(input logic [31:0] idx,
                                             input logic dir,
                                             input int unsigned depth);
    if (dir == DIR_UP) return (idx + 32'd1) % depth;
    else               return (idx + depth - 32'd1) % depth;
  endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Three-flop synchroniser for an asynchronous trigger level, with single-cycle
// rise and fall indications taken from the two settled stages.
module trig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], async_in};
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ext_code_seq.sv
// External code sequencer: a trigger-stepped walk over a programmed range of
// stored code pages, with host write/readback of the page storage.
module ext_code_seq
  import ext_code_pkg::*;
#(
  parameter int unsigned     CH_W      = 32,
  parameter int unsigned     DEPTH     = 8,
  parameter int unsigned     IDX_W     = $clog2(DEPTH),
  parameter logic [CH_W-1:0] IDLE_CODE = '0,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iWrEn,
  input  logic [IDX_W-1:0] iWrAddr,
  input  logic [CH_W-1:0]  iWrData,
  input  logic [IDX_W-1:0] iRdAddr,
  output logic [CH_W-1:0]  oRdData,
  input  logic [IDX_W-1:0] iStartIdx,
  input  logic [IDX_W-1:0] iEndIdx,
  input  logic             iDir,
  input  logic             iLoop,
  input  logic             iArm,
  input  logic             iTrigger,
  output logic [CH_W-1:0]  oCode,
  output logic [IDX_W-1:0] oIndex,
  output logic             oBusy,
  output logic             oDone,
  output logic             oStep,
  output logic [CNT_W-1:0] oTrigCnt
);

  logic [CH_W-1:0]  storage [DEPTH];
  state_t           state;
  logic [IDX_W-1:0] start_q, end_q, next_idx;
  logic             dir_q, loop_q;
  logic             rise, fall;

  trig_sync_edge u_sync (
    .clk     (iClk),
    .rst     (iRst),
    .async_in(iTrigger),
    .rise    (rise),
    .fall    (fall)
  );

  assign next_idx = IDX_W'(next_index(32'(oIndex), dir_q, DEPTH));

  // Readback is taken before the write lands, so a same-address write shows old data.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < int'(DEPTH); i++) storage[i] <= '0;
      oRdData <= '0;
    end else begin
      if (iWrEn) storage[iWrAddr] <= iWrData;
      oRdData <= storage[iRdAddr];
    end
  end

  always_ff @(posedge iClk) begin
    oStep <= 1'b0;
    if (iRst) begin
      state    <= IDLE;
      oCode    <= IDLE_CODE;
      oIndex   <= '0;
      oTrigCnt <= '0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      dir_q    <= DIR_DOWN;
      loop_q   <= 1'b0;
    end else if (iArm) begin
      start_q  <= iStartIdx;
      end_q    <= iEndIdx;
      dir_q    <= iDir;
      loop_q   <= iLoop;
      oIndex   <= iStartIdx;
      oCode    <= IDLE_CODE;
      oTrigCnt <= '0;
      oBusy    <= 1'b1;
      oDone    <= 1'b0;
      state    <= ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (rise) begin
            oCode <= storage[oIndex];
            if (oTrigCnt != '1) oTrigCnt <= oTrigCnt + CNT_W'(1);
            state <= OUTPUT;
          end
        end
        OUTPUT: begin
          // The page advances only once the trigger level has been released.
          if (fall) begin
            oCode <= IDLE_CODE;
            oStep <= 1'b1;
            if (oIndex == end_q) begin
              if (loop_q) begin
                oIndex <= start_q;
                state  <= ARMED;
              end else begin
                oBusy <= 1'b0;
                oDone <= 1'b1;
                state <= DONE;
              end
            end else begin
              oIndex <= next_idx;
              state  <= ARMED;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_code_seq.sv
// Directed and randomized checks of ext_code_seq against a page-list model of
// the sequence, the page storage and the trigger/step counts.
module tb_ext_code_seq;

  localparam int CH_W  = 32;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

  logic             iClk, iRst, iWrEn, iDir, iLoop, iArm, iTrigger;
  logic [IDX_W-1:0] iWrAddr, iRdAddr, iStartIdx, iEndIdx, oIndex;
  logic [CH_W-1:0]  iWrData, oRdData, oCode;
  logic             oBusy, oDone, oStep;
  logic [CNT_W-1:0] oTrigCnt;

  ext_code_seq #(.CH_W(CH_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst(iRst), .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iWrData(iWrData),
    .iRdAddr(iRdAddr), .oRdData(oRdData), .iStartIdx(iStartIdx), .iEndIdx(iEndIdx),
    .iDir(iDir), .iLoop(iLoop), .iArm(iArm), .iTrigger(iTrigger), .oCode(oCode),
    .oIndex(oIndex), .oBusy(oBusy), .oDone(oDone), .oStep(oStep), .oTrigCnt(oTrigCnt)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_assert = 0;
  int n_fail   = 0;
  int step_cnt = 0;

  always @(posedge iClk) begin
    #1;
    if (oStep === 1'b1) step_cnt++;
  end

  // Reference model: page contents plus the list of pages one pass visits.
  logic [31:0] mem_m [DEPTH];
  int seq_q[$];
  bit m_active, m_loop, m_done;
  int m_k, m_cnt, m_steps;

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic write_page(input int addr, input logic [31:0] data);
    iWrEn = 1'b1; iWrAddr = IDX_W'(addr); iWrData = data;
    tick(1);
    iWrEn = 1'b0;
    mem_m[addr] = data;
  endtask

  task automatic arm(input int s, input int e, input bit d, input bit l);
    int p;
    iStartIdx = IDX_W'(s); iEndIdx = IDX_W'(e); iDir = d; iLoop = l; iArm = 1'b1;
    tick(1);
    iArm = 1'b0;
    iStartIdx = IDX_W'($urandom_range(0, DEPTH-1));
    iEndIdx   = IDX_W'($urandom_range(0, DEPTH-1));
    iDir      = 1'($urandom_range(0, 1));
    iLoop     = 1'($urandom_range(0, 1));
    seq_q.delete();
    p = s;
    for (int n = 0; n < DEPTH; n++) begin
      seq_q.push_back(p);
      if (p == e) break;
      p = d ? (p + 1) % DEPTH : (p + DEPTH - 1) % DEPTH;
    end
    m_active = 1; m_loop = l; m_done = 0; m_k = 0; m_cnt = 0;
    check("arm_idx", oIndex, s);
    check("arm_code", oCode, 0);
    check("arm_busy", oBusy, 1);
    check("arm_done", oDone, 0);
    check("arm_cnt", oTrigCnt, 0);
    check("arm_step", oStep, 0);
  endtask

  // mode 1: write the served page in the rise cycle; mode 2: rewrite it mid-pulse.
  task automatic pulse(input int h, input int l, input int mode = 0, input logic [31:0] wdata = '0);
    bit srv, done;
    int pg, used;
    logic [31:0] expc;
    srv  = m_active && !m_done && (m_loop || m_k < seq_q.size());
    pg   = srv ? seq_q[m_k % seq_q.size()] : 0;
    expc = srv ? mem_m[pg] : '0;
    iTrigger = 1'b1;
    tick(2);
    check("pre_rise", oCode, 0);
    if (mode == 1) begin
      iWrEn = 1'b1; iWrAddr = IDX_W'(pg); iWrData = wdata; iRdAddr = IDX_W'(pg);
    end
    tick(1);
    iWrEn = 1'b0;
    check("rise_code", oCode, expc);
    if (srv) begin
      m_cnt++;
      check("rise_idx", oIndex, pg);
    end
    check("trig_cnt", oTrigCnt, m_cnt);
    used = 3;
    if (mode == 1) begin
      check("rd_same_cycle", oRdData, mem_m[pg]);
      mem_m[pg] = wdata;
      tick(1); used++;
      check("rd_after_wr", oRdData, wdata);
    end
    if (mode == 2) begin
      iWrEn = 1'b1; iWrAddr = IDX_W'(pg); iWrData = wdata;
      tick(1); used++;
      iWrEn = 1'b0;
      mem_m[pg] = wdata;
      check("code_hold", oCode, expc);
    end
    if (h > used) tick(h - used);
    iTrigger = 1'b0;
    tick(2);
    check("pre_fall", oCode, expc);
    tick(1);
    check("fall_code", oCode, 0);
    check("fall_step", oStep, srv);
    if (srv) begin
      m_k++; m_steps++;
      done = !m_loop && m_k == seq_q.size();
      m_done = done;
      check("next_idx", oIndex, done ? pg : seq_q[m_k % seq_q.size()]);
      check("busy", oBusy, !done);
    end
    check("done", oDone, m_done);
    if (l > 3) tick(l - 3);
    check("step_total", step_cnt, m_steps);
  endtask

  initial begin
    int base;
    iRst = 1'b1; iWrEn = 0; iWrAddr = 0; iWrData = 0; iRdAddr = 0;
    iStartIdx = 0; iEndIdx = 0; iDir = 0; iLoop = 0; iArm = 0; iTrigger = 0;
    m_active = 0; m_loop = 0; m_done = 0; m_k = 0; m_cnt = 0; m_steps = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    tick(2);
    iRst = 1'b0;
    check("rst_code", oCode, 0);
    check("rst_idx", oIndex, 0);
    check("rst_cnt", oTrigCnt, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_rd", oRdData, 0);

    $display("[TB] idle ignores triggers");
    pulse(4, 4);

    $display("[TB] one-shot down");
    for (int i = 0; i < DEPTH; i++) write_page(i, 32'hA000_0000 + 32'(i));
    arm(7, 0, 0, 0);
    for (int i = 0; i < 9; i++) pulse(10, 10);
    check("oneshot_cnt", oTrigCnt, 8);

    $display("[TB] looping up with wrap");
    arm(6, 1, 1, 1);
    base = step_cnt;
    for (int i = 0; i < 10; i++) pulse(5, 5);
    check("loop_steps", step_cnt - base, 10);
    check("loop_done", oDone, 0);

    $display("[TB] two-cycle pulse");
    iTrigger = 1'b1; tick(2); iTrigger = 1'b0;
    tick(1);
    check("p2_code", oCode, mem_m[seq_q[m_k % seq_q.size()]]);
    tick(1);
    check("p2_hold", oCode, mem_m[seq_q[m_k % seq_q.size()]]);
    tick(1);
    check("p2_fall", oCode, 0);
    check("p2_step", oStep, 1);
    m_k++; m_steps++; m_cnt++;
    tick(3);
    check("p2_idx", oIndex, seq_q[m_k % seq_q.size()]);
    check("p2_cnt", oTrigCnt, m_cnt);

    $display("[TB] write hazards");
    arm(2, 3, 1, 1);
    pulse(6, 4, 2, 32'h1234_5678);
    pulse(6, 4);
    pulse(6, 4);
    pulse(6, 4, 1, 32'hCAFE_F00D);
    pulse(6, 4);
    pulse(6, 4);

    $display("[TB] re-arm mid-pulse");
    arm(3, 6, 1, 0);
    iTrigger = 1'b1;
    tick(5);
    check("rearm_pg3", oCode, mem_m[3]);
    arm(5, 6, 1, 0);
    iTrigger = 1'b0;
    tick(6);
    check("rearm_idx", oIndex, 5);
    check("rearm_code", oCode, 0);
    check("rearm_steps", step_cnt, m_steps);
    pulse(5, 5);

    $display("[TB] randomized sequences");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) write_page(i, $urandom);
      arm($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(2, 9)) pulse($urandom_range(3, 7), $urandom_range(3, 7));
    end

    $display("[TB] reset mid-activity");
    arm(0, 7, 1, 1);
    iTrigger = 1'b1;
    tick(4);
    iRst = 1'b1;
    tick(1);
    iRst = 1'b0;
    m_active = 0; m_done = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    check("mid_rst_code", oCode, 0);
    check("mid_rst_idx", oIndex, 0);
    check("mid_rst_cnt", oTrigCnt, 0);
    check("mid_rst_busy", oBusy, 0);
    check("mid_rst_done", oDone, 0);
    check("mid_rst_step", oStep, 0);
    tick(4);
    check("mid_rst_ignored", oCode, 0);
    iTrigger = 1'b0;
    tick(4);
    for (int i = 0; i < DEPTH; i++) begin
      iRdAddr = IDX_W'(i);
      tick(1);
      check("rst_page", oRdData, mem_m[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
